intr_timer_ctrl: RTL

//  Interrupt source controller feeding the CSR unit of the 3-stage RISC-V core in CEP.

---
 rtl/intr_timer_ctrl_if.sv | 26 ++
 rtl/intr_timer_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/intr_timer_ctrl_if.sv
// Bus between intr_timer_ctrl and the CSR unit: timer control, raw external pin,
// interrupt levels and acks. The slave modport is the controller side.
interface intr_timer_ctrl_if #(
  parameter int TIMER_W = 32
);
  logic               timer_en;
  logic               counter_clear;
  logic               ext_inter;
  logic               cmp_wr;
  logic [TIMER_W-1:0] cmp_wdata;
  logic               intr_ack;
  logic               ack_ext;
  logic               timer_inter;
  logic               external_inter;
  logic [TIMER_W-1:0] mtime;

  modport master (
    output timer_en, counter_clear, ext_inter, cmp_wr, cmp_wdata, intr_ack, ack_ext,
    input  timer_inter, external_inter, mtime
  );

  modport slave (
    input  timer_en, counter_clear, ext_inter, cmp_wr, cmp_wdata, intr_ack, ack_ext,
    output timer_inter, external_inter, mtime
  );
endinterface

// File: rtl/intr_timer_ctrl.sv
// Machine timer with auto-reload plus debounced, one-shot external interrupt source.
// Optional macro INTR_PRIORITY_EN masks the timer output while the external source is pending.
module intr_timer_ctrl #(
  parameter int TIMER_W     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CMP_RST     = 100
) (
  input logic              clk,
  input logic              rst,
  intr_timer_ctrl_if.slave bus
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    EXT_IDLE,
    EXT_PEND,
    EXT_RELEASE
  } ext_state_t;

  logic [TIMER_W-1:0]     mtime_q;
  logic [TIMER_W-1:0]     mtimecmp_q;
  logic                   tmr_pend;
  logic                   ext_pend;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       deb_cnt;
  ext_state_t             ext_state;

  logic match;
  logic tmr_hit;
  logic tmr_ack;
  logic ext_ack;
  logic sync_bit;
  logic deb_done;

  assign match    = (mtime_q == mtimecmp_q);
  assign tmr_hit  = bus.timer_en && !bus.counter_clear && match;
  assign tmr_ack  = bus.intr_ack && !bus.ack_ext;
  assign ext_ack  = bus.intr_ack && bus.ack_ext;
  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign deb_done = (deb_cnt == CNT_W'(DEB_CYCLES - 1));

  // A match in the same cycle as a clearing ack or compare write keeps the timer pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= TIMER_W'(CMP_RST);
      tmr_pend   <= 1'b0;
    end else begin
      if (bus.cmp_wr) begin
        mtimecmp_q <= bus.cmp_wdata;
      end

      if (bus.counter_clear) begin
        mtime_q <= '0;
      end else if (tmr_hit) begin
        mtime_q <= '0;
      end else if (bus.timer_en) begin
        mtime_q <= mtime_q + TIMER_W'(1);
      end

      if (tmr_hit) begin
        tmr_pend <= 1'b1;
      end else if (bus.cmp_wr || tmr_ack) begin
        tmr_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else if (SYNC_STAGES > 1) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_inter};
    end else begin
      sync_q <= {SYNC_STAGES{bus.ext_inter}};
    end
  end

  // The button must be seen released for the full debounce window before it can fire again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_state <= EXT_IDLE;
      deb_cnt   <= '0;
      ext_pend  <= 1'b0;
    end else begin
      case (ext_state)
        EXT_IDLE: begin
          if (sync_bit) begin
            if (deb_done) begin
              ext_state <= EXT_PEND;
              ext_pend  <= 1'b1;
              deb_cnt   <= '0;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        EXT_PEND: begin
          if (ext_ack) begin
            ext_state <= EXT_RELEASE;
            ext_pend  <= 1'b0;
            deb_cnt   <= '0;
          end
        end
        EXT_RELEASE: begin
          if (!sync_bit) begin
            if (deb_done) begin
              ext_state <= EXT_IDLE;
              deb_cnt   <= '0;
            end else begin
              deb_cnt <= deb_cnt + CNT_W'(1);
            end
          end else begin
            deb_cnt <= '0;
          end
        end
        default: begin
          ext_state <= EXT_IDLE;
          deb_cnt   <= '0;
          ext_pend  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mtime          = mtime_q;
  assign bus.external_inter = ext_pend;
`ifdef INTR_PRIORITY_EN
  assign bus.timer_inter    = tmr_pend && !ext_pend;
`else
  assign bus.timer_inter    = tmr_pend;
`endif

endmodule
